// File: rtl/settle_pkg.sv
// Shared types and width helpers for the settling-time monitor.
package settle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int err_w(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/settle_monitor_if.sv
// Sample/target/tolerance inputs and verdict outputs of settle_monitor.
interface settle_monitor_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 7
);
    logic signed [WIDTH-1:0] v_in;
    logic signed [WIDTH-1:0] target;
    logic        [WIDTH-1:0] tol;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    settled;
    logic                    timeout;
    logic        [CNT_W-1:0] settle_time;
    logic signed [WIDTH:0]   overshoot;

    modport master (
        output v_in, target, tol, start,
        input  busy, done, settled, timeout, settle_time, overshoot
    );

    modport slave (
        input  v_in, target, tol, start,
        output busy, done, settled, timeout, settle_time, overshoot
    );
endinterface

// File: rtl/settle_monitor_band_check.sv
// Combinational tolerance-band check: err = v_in - target, in_band = |err| <= tol.
module band_check
    import settle_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0]        v_in_i,
    input  logic signed [WIDTH-1:0]        target_i,
    input  logic        [WIDTH-1:0]        tol_i,
    output logic signed [err_w(WIDTH)-1:0] err_o,
    output logic                           in_band_o
);
    localparam int EW = err_w(WIDTH);

    logic signed [EW-1:0] err;
    logic        [EW-1:0] abs_err;

    // One extra bit keeps both the difference and its magnitude exact.
    always_comb begin
        err       = {v_in_i[WIDTH-1], v_in_i} - {target_i[WIDTH-1], target_i};
        abs_err   = err[EW-1] ? -err : err;
        in_band_o = (abs_err <= {1'b0, tol_i});
        err_o     = err;
    end

endmodule

// File: rtl/settle_monitor.sv
// Step-response settling monitor; optional peak-error tracking under SETTLE_OVERSHOOT_EN.
//  state | meaning
//  IDLE  | no measurement since reset
//  RUN   | evaluating one sample per clock, counting elapsed cycles
//  DONE  | verdict held (settled/timeout, settle_time, overshoot)
module settle_monitor
    import settle_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int HOLD_CYCLES = 4,
    parameter int MAX_CYCLES  = 100,
    parameter int CNT_W       = $clog2(MAX_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    settle_monitor_if.slave mon
);
    localparam int EW = err_w(WIDTH);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     elapsed_q, elapsed_d;
    logic [CNT_W-1:0]     entry_q, entry_d;
    logic [CNT_W-1:0]     settle_time_q, settle_time_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 settled_q, settled_d;
    logic                 timeout_q, timeout_d;
    logic                 start_run;
    logic signed [EW-1:0] err;
    logic                 in_band;

    band_check #(.WIDTH(WIDTH)) u_band (
        .v_in_i   (mon.v_in),
        .target_i (mon.target),
        .tol_i    (mon.tol),
        .err_o    (err),
        .in_band_o(in_band)
    );

    always_comb begin
        state_d       = state_q;
        elapsed_d     = elapsed_q;
        entry_d       = entry_q;
        settle_time_d = settle_time_q;
        hold_d        = hold_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        settled_d     = settled_q;
        timeout_d     = timeout_q;
        start_run     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (mon.start) begin
                    state_d       = RUN;
                    busy_d        = 1'b1;
                    settled_d     = 1'b0;
                    timeout_d     = 1'b0;
                    settle_time_d = '0;
                    elapsed_d     = '0;
                    entry_d       = '0;
                    hold_d        = '0;
                    start_run     = 1'b1;
                end
            end
            RUN: begin
                if (in_band) begin
                    hold_d = hold_q + HW'(1);
                    if (hold_q == '0) entry_d = elapsed_q;
                end else begin
                    hold_d = '0;
                end
                // Settling wins over timeout when both land on the same edge.
                if (hold_d == HW'(HOLD_CYCLES)) begin
                    state_d       = DONE;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    settled_d     = 1'b1;
                    settle_time_d = entry_d;
                end else if (elapsed_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d       = DONE;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    timeout_d     = 1'b1;
                    settle_time_d = '0;
                end else begin
                    elapsed_d = elapsed_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            elapsed_q     <= '0;
            entry_q       <= '0;
            settle_time_q <= '0;
            hold_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            settled_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            elapsed_q     <= elapsed_d;
            entry_q       <= entry_d;
            settle_time_q <= settle_time_d;
            hold_q        <= hold_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            settled_q     <= settled_d;
            timeout_q     <= timeout_d;
        end
    end

    assign mon.busy        = busy_q;
    assign mon.done        = done_q;
    assign mon.settled     = settled_q;
    assign mon.timeout     = timeout_q;
    assign mon.settle_time = settle_time_q;

`ifdef SETTLE_OVERSHOOT_EN
    logic signed [EW-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (start_run) begin
            peak_d = {1'b1, {(EW-1){1'b0}}};
        end else if (state_q == RUN && err > peak_q) begin
            peak_d = err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) peak_q <= '0;
        else      peak_q <= peak_d;
    end

    assign mon.overshoot = peak_q;
`else
    logic unused_err;

    assign unused_err    = ^{err, start_run};
    assign mon.overshoot = '0;
`endif

endmodule

// File: doc/settle_monitor.md
# settle_monitor

Downstream observer for the filter stage: consumes the filter's fixed-point output sample each clock and measures step-response settling against a target value and tolerance band. On `start` it runs a cycle counter and reports either the settling time (first cycle of the final in-band run lasting `HOLD_CYCLES`) or a timeout. It sits beside the `DUMP_REAL_TO_FILE` probe in the top-level bench and gives the emulator a pass/fail verdict without offline post-processing.

## Interface
- `WIDTH`, 16: signed width of `v_in` and `target`, and unsigned width of `tol`. All three share one fixed-point exponent, so raw integers are compared directly.
- `HOLD_CYCLES`, 4: consecutive in-band samples required to declare settling. Must be ≥1.
- `MAX_CYCLES`, 100: run length before timeout. Must be ≥ `HOLD_CYCLES`.
- `CNT_W`, `$clog2(MAX_CYCLES+1)`: counter width (derived).

Ports:
- `clk` in 1: sample clock, the same clock as the filter.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `v_in` in WIDTH signed: filter output sample (`v_out` of filter).
- `target` in WIDTH signed: expected final value. Held stable during a run.
- `tol` in WIDTH unsigned: band half-width. Held stable during a run.
- `start` in 1: single-cycle request to begin a measurement.
- `busy` out 1: a measurement is running.
- `done` out 1: one-cycle pulse when a run ends.
- `settled` out 1: the last run settled. Sticky until the next start.
- `timeout` out 1: the last run timed out. Sticky until the next start.
- `settle_time` out CNT_W: elapsed count at entry of the final in-band run.
- `overshoot` out WIDTH+1 signed: peak of `v_in − target` seen during the run.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE on settle or timeout.
  - DONE → RUN on `start`.
  - `start` is ignored in RUN.
- Each RUN edge, band check:
  - `err = v_in − target`, computed at WIDTH+1 bits signed.
  - `in_band = |err| ≤ tol`, compared at WIDTH+1 bits, so no overflow is possible.
  - `|err| == tol` counts as in band.
- RUN edge bookkeeping (`elapsed` counts from 0):
  - If `in_band`: `hold_cnt++`. If `hold_cnt` was 0, then `entry_time ← elapsed`.
  - Else: `hold_cnt ← 0`.
  - If `hold_cnt` reaches `HOLD_CYCLES` on this edge: go to DONE, set `settled=1`, `settle_time ← entry_time`.
  - Else, if `elapsed == MAX_CYCLES−1`: go to DONE, set `timeout=1`, `settle_time ← 0`.
  - Settle has priority over timeout on the same edge.
  - `elapsed++` otherwise.
- On `start` (from IDLE or DONE), cleared on the same edge: `settled`, `timeout`, `settle_time`, `elapsed`, `hold_cnt`, and `overshoot` (set to the most negative value).
- Reset while any state is active returns to IDLE immediately. An in-flight run is discarded.

## Timing
- Reset values: `busy=0`, `done=0`, `settled=0`, `timeout=0`, `settle_time=0`, `overshoot=0`.
- All outputs are registered.
- `start` sampled at edge k:
  - `busy=1` from k+1.
  - The first evaluated sample is `v_in` at edge k+1, which is `elapsed=0`.
- Ending edge e (the edge that reaches settle or timeout):
  - After edge e: `busy=0`, `done=1` for exactly one cycle, and `settled` or `timeout` is valid with `settle_time`.
  - Minimum run (in band from the first sample): `done` after edge k+`HOLD_CYCLES`.
  - Timeout run: `done` after edge k+`MAX_CYCLES`.
- A `start` in the same cycle as `done` is accepted. The FSM is in DONE and re-enters RUN.

## Configuration
- `SETTLE_OVERSHOOT_EN` defined:
  - Each RUN edge updates `overshoot ← max(overshoot, err)`.
  - The value is reported after `done` and held until the next start.
- Not defined:
  - No peak register is synthesized.
  - `overshoot` is tied to 0 permanently, including after start.

## Structure
- Package `settle_pkg`:
  - `state_t` enum (IDLE, RUN, DONE).
  - Function `err_w(WIDTH)` returning WIDTH+1.
- Sub-module `band_check`: combinational block computing `err`, `|err|`, and `in_band` from `v_in`, `target`, `tol`. The FSM, counters and overshoot register live in `settle_monitor`.

## Test plan
Common setup: WIDTH=16, target=1000, tol=50, HOLD_CYCLES=4, MAX_CYCLES=100.
1. `v_in=1000` constant, `start` at edge 0 → `done` after edge 4, `settled=1`, `settle_time=0`, `timeout=0`.
2. `v_in=0` for 10 samples then 1000 → `settled=1`, `settle_time=10`, `done` after edge 14.
3. In band for samples 3–5, out at 6, in from 20 onward → `settle_time=20`. The band exit resets the hold count.
4. `v_in=1050` → in band. `v_in=1051` constant → `timeout=1`, `settled=0`, `done` after edge 100.
5. With `SETTLE_OVERSHOOT_EN`: ramp to 1080, then hold 1000 → `overshoot=80`. Without the macro → `overshoot=0`.
6. Assert `rst` low at elapsed 7 → all outputs 0 asynchronously, IDLE. A `start` pulsed while `busy` is ignored, and `elapsed` is not restarted.
